// File: rtl/arb_out_buffer.sv
// Registered 32-bit first-word-fall-through buffer with occupancy, near-full and read-error reporting.
// Optional drop/peak statistics are built only when ARB_OUT_BUFFER_STATS_EN is defined.
module arb_out_buffer #(
   parameter int ADDR_WIDTH          = 4,
   parameter int NEAR_FULL_THRESHOLD = 12
) (
   input  logic                  BUS_CLK,
   input  logic                  BUS_RST,
   input  logic                  FLUSH,
   input  logic                  IN_WRITE,
   input  logic [31:0]           IN_DATA,
   output logic                  IN_READY,
   input  logic                  FIFO_READ,
   output logic                  FIFO_EMPTY,
   output logic [31:0]           FIFO_DATA,
   output logic                  FIFO_NEAR_FULL,
   output logic [ADDR_WIDTH:0]   OCCUPANCY,
   output logic                  READ_ERROR,
   output logic [15:0]           DROP_CNT,
   output logic [ADDR_WIDTH:0]   MAX_OCCUPANCY
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] NF_TH   = (ADDR_WIDTH+1)'(NEAR_FULL_THRESHOLD);

   logic [31:0]           mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
   logic                  empty_q, nfull_q, rerr_q, rerr_d;
   logic                  wr_acc, rd_ok;

   assign IN_READY = (cnt_q != DEPTH_C);
   assign wr_acc   = IN_WRITE & IN_READY & ~FLUSH;
   assign rd_ok    = FIFO_READ & ~empty_q & ~FLUSH;

   always_comb begin
      wp_d   = wp_q;
      rp_d   = rp_q;
      cnt_d  = cnt_q;
      rerr_d = rerr_q;
      if (FLUSH) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (wr_acc) wp_d = wp_q + 1'b1;
         if (rd_ok)  rp_d = rp_q + 1'b1;
         case ({wr_acc, rd_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
         if (FIFO_READ && empty_q) rerr_d = 1'b1;
      end
   end

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         empty_q <= 1'b1;
         nfull_q <= 1'b0;
         rerr_q  <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         cnt_q   <= cnt_d;
         empty_q <= (cnt_d == '0);
         nfull_q <= (cnt_d >= NF_TH);
         rerr_q  <= rerr_d;
      end
   end

   // Storage holds data only; contents after reset are don't-care because the head is masked while empty.
   always_ff @(posedge BUS_CLK) begin
      if (wr_acc) mem[wp_q] <= IN_DATA;
   end

   assign FIFO_DATA      = empty_q ? 32'd0 : mem[rp_q];
   assign FIFO_EMPTY     = empty_q;
   assign FIFO_NEAR_FULL = nfull_q;
   assign OCCUPANCY      = cnt_q;
   assign READ_ERROR     = rerr_q;

`ifdef ARB_OUT_BUFFER_STATS_EN
   logic [15:0]         drop_q;
   logic [ADDR_WIDTH:0] max_q;

   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         drop_q <= '0;
         max_q  <= '0;
      end else begin
         if (IN_WRITE && !IN_READY && !FLUSH && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
         if (cnt_q > max_q) max_q <= cnt_q;
      end
   end

   assign DROP_CNT      = drop_q;
   assign MAX_OCCUPANCY = max_q;
`else
   assign DROP_CNT      = '0;
   assign MAX_OCCUPANCY = '0;
`endif

endmodule

// File: tb/tb_arb_out_buffer.sv
// Directed self-checking bench for arb_out_buffer (default parameters, DEPTH = 16).
module tb_arb_out_buffer;

   logic        clk = 1'b0;
   logic        rst, flush, in_write, fifo_read;
   logic [31:0] in_data;
   logic        in_ready, fifo_empty, fifo_near_full, read_error;
   logic [31:0] fifo_data;
   logic [4:0]  occupancy, max_occ;
   logic [15:0] drop_cnt;

   int checks   = 0;
   int failures = 0;

`ifdef ARB_OUT_BUFFER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   arb_out_buffer #(.ADDR_WIDTH(4), .NEAR_FULL_THRESHOLD(12)) dut (
      .BUS_CLK       (clk),
      .BUS_RST       (rst),
      .FLUSH         (flush),
      .IN_WRITE      (in_write),
      .IN_DATA       (in_data),
      .IN_READY      (in_ready),
      .FIFO_READ     (fifo_read),
      .FIFO_EMPTY    (fifo_empty),
      .FIFO_DATA     (fifo_data),
      .FIFO_NEAR_FULL(fifo_near_full),
      .OCCUPANCY     (occupancy),
      .READ_ERROR    (read_error),
      .DROP_CNT      (drop_cnt),
      .MAX_OCCUPANCY (max_occ)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_empty"}, {31'd0, fifo_empty}, 32'd1);
      chk({tag, "_near_full"}, {31'd0, fifo_near_full}, 32'd0);
      chk({tag, "_occ"}, {27'd0, occupancy}, 32'd0);
      chk({tag, "_rerr"}, {31'd0, read_error}, 32'd0);
      chk({tag, "_drop"}, {16'd0, drop_cnt}, 32'd0);
      chk({tag, "_max"}, {27'd0, max_occ}, 32'd0);
      chk({tag, "_data"}, fifo_data, 32'd0);
   endtask

   task automatic write_word(input logic [31:0] d);
      in_write = 1'b1;
      in_data  = d;
      step();
      in_write = 1'b0;
   endtask

   initial begin
      logic [31:0] exp_r, next_w;
      rst = 1'b1; flush = 1'b0; in_write = 1'b0; fifo_read = 1'b0; in_data = '0;
      step(); step();
      rst = 1'b0;
      chk_reset_state("reset");

      // Single word fall-through and read back
      write_word(32'hDEADBEEF);
      chk("single_empty", {31'd0, fifo_empty}, 32'd0);
      chk("single_data", fifo_data, 32'hDEADBEEF);
      chk("single_occ", {27'd0, occupancy}, 32'd1);
      fifo_read = 1'b1; step(); fifo_read = 1'b0;
      chk("single_read_empty", {31'd0, fifo_empty}, 32'd1);
      chk("single_read_occ", {27'd0, occupancy}, 32'd0);

      // Fill to full, watch near-full and ready
      for (int i = 0; i < 16; i++) begin
         write_word(32'(i));
         chk($sformatf("fill_occ_%0d", i), {27'd0, occupancy}, 32'(i + 1));
         chk($sformatf("fill_nf_%0d", i), {31'd0, fifo_near_full}, (i + 1 >= 12) ? 32'd1 : 32'd0);
         chk($sformatf("fill_rdy_%0d", i), {31'd0, in_ready}, (i + 1 != 16) ? 32'd1 : 32'd0);
      end
      write_word(32'hBAD);
      chk("full_drop_occ", {27'd0, occupancy}, 32'd16);
      chk("full_drop_head", fifo_data, 32'd0);
      chk("full_drop_cnt", {16'd0, drop_cnt}, STATS ? 32'd1 : 32'd0);
      fifo_read = 1'b1;
      for (int i = 0; i < 16; i++) begin
         chk($sformatf("drain_data_%0d", i), fifo_data, 32'(i));
         step();
         if (i == 0) chk("full_ready_after_read", {31'd0, in_ready}, 32'd1);
      end
      fifo_read = 1'b0;
      chk("drain_empty", {31'd0, fifo_empty}, 32'd1);
      chk("drain_nf", {31'd0, fifo_near_full}, 32'd0);
      chk("drain_max", {27'd0, max_occ}, STATS ? 32'd16 : 32'd0);

      // Streaming at occupancy 3 across pointer wrap
      next_w = 32'd100;
      exp_r  = 32'd100;
      for (int i = 0; i < 3; i++) begin
         write_word(next_w);
         next_w++;
      end
      in_write = 1'b1; fifo_read = 1'b1;
      for (int i = 0; i < 40; i++) begin
         in_data = next_w;
         chk($sformatf("stream_data_%0d", i), fifo_data, exp_r);
         step();
         next_w++;
         exp_r++;
         chk($sformatf("stream_occ_%0d", i), {27'd0, occupancy}, 32'd3);
      end
      in_write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("stream_tail_%0d", i), fifo_data, exp_r);
         step();
         exp_r++;
      end
      fifo_read = 1'b0;
      chk("stream_end_empty", {31'd0, fifo_empty}, 32'd1);

      // Read while empty sets the sticky error
      fifo_read = 1'b1; step(); fifo_read = 1'b0;
      chk("rerr_set", {31'd0, read_error}, 32'd1);
      chk("rerr_occ", {27'd0, occupancy}, 32'd0);
      write_word(32'h1234);
      chk("rerr_wdata", fifo_data, 32'h1234);
      fifo_read = 1'b1; step(); fifo_read = 1'b0;
      chk("rerr_sticky", {31'd0, read_error}, 32'd1);
      rst = 1'b1; step(); rst = 1'b0;
      chk("rerr_cleared", {31'd0, read_error}, 32'd0);

      // Flush at occupancy 7 with a simultaneous write
      for (int i = 0; i < 7; i++) write_word(32'(200 + i));
      chk("pre_flush_occ", {27'd0, occupancy}, 32'd7);
      flush = 1'b1; in_write = 1'b1; in_data = 32'h777;
      step();
      flush = 1'b0; in_write = 1'b0;
      chk("flush_occ", {27'd0, occupancy}, 32'd0);
      chk("flush_empty", {31'd0, fifo_empty}, 32'd1);
      chk("flush_max", {27'd0, max_occ}, STATS ? 32'd7 : 32'd0);
      write_word(32'h55);
      chk("post_flush_data", fifo_data, 32'h55);
      chk("post_flush_occ", {27'd0, occupancy}, 32'd1);
      chk("post_flush_max", {27'd0, max_occ}, STATS ? 32'd7 : 32'd0);
      fifo_read = 1'b1; step(); fifo_read = 1'b0;
      chk("post_flush_drained", {31'd0, fifo_empty}, 32'd1);

      // Reset mid-stream at occupancy 5
      for (int i = 0; i < 5; i++) write_word(32'(300 + i));
      chk("pre_rst_occ", {27'd0, occupancy}, 32'd5);
      rst = 1'b1; in_write = 1'b1; fifo_read = 1'b1; in_data = 32'h999;
      step();
      rst = 1'b0; in_write = 1'b0; fifo_read = 1'b0;
      chk_reset_state("midrst");
      write_word(32'hCAFE);
      chk("post_rst_data", fifo_data, 32'hCAFE);
      chk("post_rst_empty", {31'd0, fifo_empty}, 32'd0);
      chk("post_rst_occ", {27'd0, occupancy}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
